btn_debounce_step: RTL and testbench

Debounces the board's raw push-buttons and converts them into clean levels plus single-cycle event strobes for the single-step CPU. It sits between the button pins and the CPU core: the CPU step clock and the PC/register reset are taken from its `btn_level` outputs. The front panel takes `btn_event` for counters and menus. Each button has a two-flop synchronizer, a stability counter and an optional hold-to-repeat generator.

---
 rtl/btn_pkg.sv | 23 ++
 rtl/btn_debounce_chan.sv | 139 +++++++++++++
 rtl/btn_debounce_step.sv | 54 +++++
 tb/tb_btn_debounce_step.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg
// Shared definitions for the button debounce / step block:
//   - default timing parameters (50 MHz board clock)
//   - rep_state_t : hold-to-repeat FSM state encoding
//   - cnt_width() : counter width helper that never returns zero
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;    // 10 ms at 50 MHz
    localparam int REPEAT_DELAY_DEF    = 25000000;  // 500 ms to first repeat
    localparam int REPEAT_RATE_DEF     = 5000000;   // 100 ms between repeats

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// btn_debounce_chan
// One button channel: two-flop synchronizer, stability counter producing a
// debounced level with press/release strobes, and a hold-to-repeat FSM.
//
// Ports:
//   clk           board clock, rising edge
//   rst_n         synchronous active-low reset
//   btn_raw       asynchronous bouncing pin, active-high
//   repeat_en     enables hold-to-repeat for this channel
//   btn_level     debounced level
//   btn_press     one-cycle strobe on accepted 0->1
//   btn_release   one-cycle strobe on accepted 1->0
//   repeat_strobe one-cycle strobe from the repeat generator
//
// Repeat FSM:
//   state  | meaning
//   IDLE   | no press being held, or repeat disabled
//   DELAY  | press accepted, counting to first repeat
//   REPEAT | emitting a strobe every REPEAT_RATE cycles
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic repeat_strobe
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          press_acc;
    logic          rel_acc;

    rep_state_t    state;
    rep_state_t    state_nxt;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_nxt;
    logic          strobe_nxt;

    // Level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES edges.
    assign accept    = (s2 != btn_level) && (cnt == CNT_LAST);
    assign press_acc = accept && !btn_level;
    assign rel_acc   = accept &&  btn_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            btn_press   <= press_acc;
            btn_release <= rel_acc;
            if (s2 == btn_level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt       <= '0;
                btn_level <= ~btn_level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rcnt          <= '0;
            repeat_strobe <= 1'b0;
        end else begin
            state         <= state_nxt;
            rcnt          <= rcnt_nxt;
            repeat_strobe <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        strobe_nxt = 1'b0;
        // Release or disable wins over everything, including a due strobe.
        if (!repeat_en || rel_acc) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    rcnt_nxt = '0;
                    if (press_acc) begin
                        state_nxt = DELAY;
                    end
                end
                DELAY: begin
                    if (rcnt == DELAY_LAST) begin
                        strobe_nxt = 1'b1;
                        rcnt_nxt   = '0;
                        state_nxt  = REPEAT;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt == RATE_LAST) begin
                        strobe_nxt = 1'b1;
                        rcnt_nxt   = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_step.sv
// btn_debounce_step
// Debounces N_BTN raw push-buttons into clean levels plus press / release /
// event strobes for the single-step CPU and front panel.
//
// Ports:
//   clk          board clock (BUFG output), rising edge
//   rst_n        synchronous active-low reset
//   btn_raw      asynchronous bouncing pins, active-high
//   repeat_en    per-channel hold-to-repeat enable
//   btn_level    debounced levels
//   btn_press    one-cycle strobe per accepted 0->1
//   btn_release  one-cycle strobe per accepted 1->0
//   btn_event    btn_press OR repeat strobe
module btn_debounce_step
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_event
);

    logic [N_BTN-1:0] rep_strobe;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .btn_raw      (btn_raw[i]),
            .repeat_en    (repeat_en[i]),
            .btn_level    (btn_level[i]),
            .btn_press    (btn_press[i]),
            .btn_release  (btn_release[i]),
            .repeat_strobe(rep_strobe[i])
        );
    end

    // Press and repeat never coincide: the repeat count starts at the press.
    assign btn_event = btn_press | rep_strobe;

endmodule

// File: tb/tb_btn_debounce_step.sv
module tb_btn_debounce_step;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_event;

    int errors = 0;
    int checks = 0;

    // Reference model state: sample history, disagreement run length,
    // edges since accepted press while repeat stays armed.
    logic [N-1:0] h1, h2;
    logic [N-1:0] m_level, m_press, m_release, m_rep;
    logic [N-1:0] m_armed;
    int           m_run [N];
    int           m_age [N];
    logic [N-1:0] m_event;

    btn_debounce_step #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_event  (btn_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one rising edge, update the model from the inputs that edge
    // saw, then settle 1 time unit so the DUT outputs can be sampled.
    task automatic tick();
        logic seen;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            m_rep[i]     = 1'b0;
            if (!rst_n) begin
                h1[i] = 1'b0; h2[i] = 1'b0; m_level[i] = 1'b0;
                m_armed[i] = 1'b0; m_run[i] = 0; m_age[i] = 0;
            end else begin
                seen  = h2[i];
                h2[i] = h1[i];
                h1[i] = btn_raw[i];
                if (seen != m_level[i]) m_run[i]++;
                else                    m_run[i] = 0;
                if (m_run[i] == DEB) begin
                    m_run[i]   = 0;
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) begin
                        m_press[i] = 1'b1;
                        m_armed[i] = repeat_en[i];
                        m_age[i]   = 0;
                    end else begin
                        m_release[i] = 1'b1;
                        m_armed[i]   = 1'b0;
                    end
                end else if (m_armed[i]) begin
                    if (!repeat_en[i]) begin
                        m_armed[i] = 1'b0;
                    end else begin
                        m_age[i]++;
                        if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RR == 0))
                            m_rep[i] = 1'b1;
                    end
                end
            end
        end
        m_event = m_press | m_rep;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        btn_raw   = '0;
        repeat_en = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_event} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0000",
                     {btn_level, btn_press, btn_release, btn_event});
        end
        for (int e = 0; e < 6; e++) begin
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release, btn_event} !== {m_level, m_press, m_release, m_event}) begin
                errors++;
                $display("FAIL reset_idle e=%0d: got %h required %h", e,
                         {btn_level, btn_press, btn_release, btn_event}, {m_level, m_press, m_release, m_event});
            end
        end
    endtask

    task automatic test_clean_press_release();
        do_reset();
        btn_raw[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (btn_level[0] !== (e >= 5) || btn_press[0] !== (e == 5) ||
                btn_event[0] !== (e == 5) || btn_release[0] !== 1'b0) begin
                errors++;
                $display("FAIL clean_press e=%0d: got lvl=%b prs=%b evt=%b rel=%b required lvl=%b prs=%b evt=%b rel=0",
                         e, btn_level[0], btn_press[0], btn_event[0], btn_release[0], e >= 5, e == 5, e == 5);
            end
        end
        btn_raw[0] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (btn_level[0] !== (e < 5) || btn_release[0] !== (e == 5) || btn_press[0] !== 1'b0) begin
                errors++;
                $display("FAIL release e=%0d: got lvl=%b rel=%b prs=%b required lvl=%b rel=%b prs=0",
                         e, btn_level[0], btn_release[0], btn_press[0], e < 5, e == 5);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
        do_reset();
        for (int e = 0; e < 14; e++) begin
            btn_raw[1] = (e < 5) ? pat[e] : 1'b1;
            tick();
            checks++;
            if (btn_level[1] !== (e >= 10) || btn_press[1] !== (e == 10) || btn_event[1] !== (e == 10)) begin
                errors++;
                $display("FAIL bounce e=%0d: got lvl=%b prs=%b evt=%b required lvl=%b prs=%b",
                         e, btn_level[1], btn_press[1], btn_event[1], e >= 10, e == 10);
            end
        end
    endtask

    task automatic test_repeat();
        logic exp;
        do_reset();
        repeat_en[2] = 1'b1;
        btn_raw[2]   = 1'b1;
        for (int e = 0; e < 22; e++) begin
            tick();
            exp = (e == 5 || e == 15 || e == 18 || e == 21);
            checks++;
            if (btn_event[2] !== exp || btn_press[2] !== (e == 5)) begin
                errors++;
                $display("FAIL repeat_hold e=%0d: got evt=%b prs=%b required evt=%b prs=%b",
                         e, btn_event[2], btn_press[2], exp, e == 5);
            end
        end
        btn_raw[2] = 1'b0;
        for (int e = 22; e < 45; e++) begin
            tick();
            checks++;
            if (btn_event[2] !== (e == 24) || btn_release[2] !== (e == 27)) begin
                errors++;
                $display("FAIL repeat_release e=%0d: got evt=%b rel=%b required evt=%b rel=%b",
                         e, btn_event[2], btn_release[2], e == 24, e == 27);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset();
        repeat_en[2] = 1'b1;
        btn_raw[2]   = 1'b1;
        for (int e = 0; e < 18; e++) begin
            tick();
            checks++;
            if (btn_event[2] !== (e == 5 || e == 15)) begin
                errors++;
                $display("FAIL pre_reset e=%0d: got evt=%b required %b", e, btn_event[2], e == 5 || e == 15);
            end
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_event} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h required 0000",
                     {btn_level, btn_press, btn_release, btn_event});
        end
        tick();
        rst_n = 1'b1;
        for (int f = 0; f < 20; f++) begin
            tick();
            exp = (f == 5 || f == 15 || f == 18);
            checks++;
            if (btn_press[2] !== (f == 5) || btn_event[2] !== exp || btn_level[2] !== (f >= 5)) begin
                errors++;
                $display("FAIL post_reset f=%0d: got prs=%b evt=%b lvl=%b required prs=%b evt=%b lvl=%b",
                         f, btn_press[2], btn_event[2], btn_level[2], f == 5, exp, f >= 5);
            end
        end
    endtask

    task automatic test_repeat_en_toggle();
        do_reset();
        repeat_en[2] = 1'b1;
        btn_raw[2]   = 1'b1;
        for (int e = 0; e < 30; e++) begin
            if (e == 8)  repeat_en[2] = 1'b0;  // mid DELAY
            if (e == 11) repeat_en[2] = 1'b1;  // must not resume
            tick();
            checks++;
            if (btn_event[2] !== (e == 5)) begin
                errors++;
                $display("FAIL en_toggle e=%0d: got evt=%b required %b", e, btn_event[2], e == 5);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        btn_raw = '1;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (btn_press !== ((e == 5) ? 4'hF : 4'h0) || btn_event !== btn_press) begin
                errors++;
                $display("FAIL simultaneous e=%0d: got prs=%b evt=%b required prs=%b",
                         e, btn_press, btn_event, (e == 5) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_random();
        int lim;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                lim = (i >= 2) ? 40 : 7;
                if ($urandom_range(0, lim) == 0) btn_raw[i] = ~btn_raw[i];
                if ($urandom_range(0, 80) == 0)  repeat_en[i] = ~repeat_en[i];
            end
            tick();
            checks++;
            if ({btn_level, btn_press, btn_release, btn_event} !== {m_level, m_press, m_release, m_event}) begin
                errors++;
                $display("FAIL random c=%0d: got lvl=%b prs=%b rel=%b evt=%b required lvl=%b prs=%b rel=%b evt=%b",
                         c, btn_level, btn_press, btn_release, btn_event, m_level, m_press, m_release, m_event);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_raw   = '0;
        repeat_en = '0;
        h1 = '0; h2 = '0; m_level = '0; m_press = '0; m_release = '0;
        m_rep = '0; m_armed = '0; m_event = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
        #2;
        test_reset();
        test_clean_press_release();
        test_bounce();
        test_repeat();
        test_reset_mid();
        test_repeat_en_toggle();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
